// File: rtl/uart_pkg.sv
// Shared UART definitions for the clk_50m domain: FSM state codes and oversampling defaults.
// Used by both uart_trx and uart_rcv.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE  = 2'd0;
  localparam uart_state_t START = 2'd1;
  localparam uart_state_t DATA  = 2'd2;
  localparam uart_state_t STOP  = 2'd3;

  localparam int OVERSAMPLE_DEF = 16;

  // Tick index within the start bit that is taken as the bit centre.
  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rcv_if.sv
// Line-side and consumer-side signals of the UART receiver.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rcv_if;

  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output rx, clken, rdy_clr,
    input  dout, rdy, frame_err, overrun, rx_busy
  );

  modport slave (
    input  rx, clken, rdy_clr,
    output dout, rdy, frame_err, overrun, rx_busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so that a line at rest never looks like a start bit.
module uart_sync2 (
  input  logic clk_50m,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rcv.sv
// UART 8N1 receiver, LSB first, sampling a synchronized line on a 16x-baud strobe.
// Holds the last good byte with a sticky ready flag plus framing and overrun flags.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic     clk_50m,
  input logic     rst,
  uart_rcv_if.slave bus
);

  localparam int                SAMP_W    = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(mid_tick(OVERSAMPLE));
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);

  logic              rx_s;
  uart_state_t       state;
  logic [SAMP_W-1:0] sample;
  logic [2:0]        bitpos;
  logic [7:0]        shreg;
  logic [7:0]        dout_q;
  logic              rdy_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              stop_done;
  logic              stop_good;
  logic              stop_bad;

  uart_sync2 u_sync (
    .clk_50m (clk_50m),
    .rst     (rst),
    .d       (bus.rx),
    .q       (rx_s)
  );

  // Start is confirmed at its centre; from there every OVERSAMPLE ticks lands on the next bit centre.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sample <= '0;
      bitpos <= '0;
      shreg  <= '0;
    end else if (bus.clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            sample <= '0;
          end
        end
        START: begin
          if (rx_s) begin
            state <= IDLE;
          end else if (sample == SAMP_MID) begin
            state  <= DATA;
            sample <= '0;
            bitpos <= '0;
          end else begin
            sample <= sample + SAMP_ONE;
          end
        end
        DATA: begin
          if (sample == SAMP_LAST) begin
            sample        <= '0;
            shreg[bitpos] <= rx_s;
            if (bitpos == 3'd7) begin
              state <= STOP;
            end else begin
              bitpos <= bitpos + 3'd1;
            end
          end else begin
            sample <= sample + SAMP_ONE;
          end
        end
        STOP: begin
          if (sample == SAMP_LAST) begin
            state  <= IDLE;
            sample <= '0;
          end else begin
            sample <= sample + SAMP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_done = bus.clken && (state == STOP) && (sample == SAMP_LAST);
  assign stop_good = stop_done && rx_s;
  assign stop_bad  = stop_done && !rx_s;

  // A completing frame takes priority over a simultaneous acknowledge.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      dout_q      <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (stop_good) begin
      dout_q      <= shreg;
      rdy_q       <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= bus.rdy_clr ? 1'b0 : (overrun_q | rdy_q);
    end else if (stop_bad) begin
      frame_err_q <= 1'b1;
      if (bus.rdy_clr) begin
        rdy_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
    end else if (bus.rdy_clr) begin
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv: serial frames driven tick by tick, outputs checked
// with immediate assertions against hand-computed values.
module tb_uart_rcv;

  logic clk_50m;
  logic rst;
  int   total;
  int   bad;

  uart_rcv_if bus ();

  uart_rcv #(.OVERSAMPLE(16)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clken strobe every fourth clock; rdy_clr can ride along with the strobe.
  task automatic tick(input logic clr);
    repeat (3) @(negedge clk_50m);
    bus.clken   = 1'b1;
    bus.rdy_clr = clr;
    @(negedge clk_50m);
    bus.clken   = 1'b0;
    bus.rdy_clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // Stop-bit tick 8 is the one on which the receiver completes the frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic clr_at_done);
    bus.rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      ticks(16);
    end
    bus.rx = stop_bit;
    for (int i = 0; i < 16; i++) tick(clr_at_done && (i == 8));
    bus.rx = 1'b1;
  endtask

  task automatic pulseClear();
    @(negedge clk_50m);
    bus.rdy_clr = 1'b1;
    @(negedge clk_50m);
    bus.rdy_clr = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.rx      = 1'b1;
    bus.clken   = 1'b0;
    bus.rdy_clr = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);

    checkOutput("reset_dout", bus.dout, 8'h00);
    checkOutput("reset_rdy", bus.rdy, 1'b0);
    checkOutput("reset_ferr", bus.frame_err, 1'b0);
    checkOutput("reset_ovr", bus.overrun, 1'b0);
    checkOutput("reset_busy", bus.rx_busy, 1'b0);

    // 1: good byte, then acknowledge
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("t1_dout", bus.dout, 8'hA5);
    checkOutput("t1_rdy", bus.rdy, 1'b1);
    checkOutput("t1_ferr", bus.frame_err, 1'b0);
    checkOutput("t1_ovr", bus.overrun, 1'b0);
    checkOutput("t1_busy", bus.rx_busy, 1'b0);
    pulseClear();
    checkOutput("t1_rdy_clr", bus.rdy, 1'b0);

    // 2: start-bit glitch of five ticks
    bus.rx = 1'b0;
    ticks(2);
    checkOutput("t2_busy_hi", bus.rx_busy, 1'b1);
    ticks(3);
    bus.rx = 1'b1;
    ticks(2);
    checkOutput("t2_busy_lo", bus.rx_busy, 1'b0);
    checkOutput("t2_rdy", bus.rdy, 1'b0);
    checkOutput("t2_ferr", bus.frame_err, 1'b0);
    checkOutput("t2_dout", bus.dout, 8'hA5);

    // 3: bad stop bit, line held high long enough to drop the false start, then a good frame
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("t3_ferr", bus.frame_err, 1'b1);
    checkOutput("t3_rdy", bus.rdy, 1'b0);
    checkOutput("t3_dout", bus.dout, 8'hA5);
    ticks(4);
    checkOutput("t3_busy", bus.rx_busy, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    checkOutput("t3_ferr_clr", bus.frame_err, 1'b0);
    checkOutput("t3_dout2", bus.dout, 8'h81);
    checkOutput("t3_rdy2", bus.rdy, 1'b1);
    pulseClear();
    checkOutput("t3_rdy_clr", bus.rdy, 1'b0);

    // 4: back-to-back frames without acknowledge
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("t4_dout1", bus.dout, 8'h55);
    checkOutput("t4_ovr1", bus.overrun, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    checkOutput("t4_ovr2", bus.overrun, 1'b1);
    checkOutput("t4_dout2", bus.dout, 8'hC3);
    checkOutput("t4_rdy", bus.rdy, 1'b1);
    checkOutput("t4_ferr", bus.frame_err, 1'b0);
    pulseClear();
    checkOutput("t4_clr_rdy", bus.rdy, 1'b0);
    checkOutput("t4_clr_ovr", bus.overrun, 1'b0);
    checkOutput("t4_clr_ferr", bus.frame_err, 1'b0);

    // 5: acknowledge lands on the completion edge while a byte is pending
    applyStimulus(8'h99, 1'b1, 1'b0);
    checkOutput("t5_pre_rdy", bus.rdy, 1'b1);
    applyStimulus(8'h7E, 1'b1, 1'b1);
    checkOutput("t5_rdy", bus.rdy, 1'b1);
    checkOutput("t5_ovr", bus.overrun, 1'b0);
    checkOutput("t5_dout", bus.dout, 8'h7E);

    // 6: reset in the middle of the data bits of 0xFF
    bus.rx = 1'b0;
    ticks(16);
    bus.rx = 1'b1;
    ticks(40);
    checkOutput("t6_busy_pre", bus.rx_busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t6_dout", bus.dout, 8'h00);
    checkOutput("t6_rdy", bus.rdy, 1'b0);
    checkOutput("t6_ferr", bus.frame_err, 1'b0);
    checkOutput("t6_ovr", bus.overrun, 1'b0);
    checkOutput("t6_busy", bus.rx_busy, 1'b0);
    @(negedge clk_50m);
    rst = 1'b0;
    ticks(4);
    applyStimulus(8'h12, 1'b1, 1'b0);
    checkOutput("t6_dout2", bus.dout, 8'h12);
    checkOutput("t6_rdy2", bus.rdy, 1'b1);
    checkOutput("t6_ferr2", bus.frame_err, 1'b0);
    checkOutput("t6_ovr2", bus.overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
Name: uart_rcv

Overview:
UART receiver, the receive-side counterpart of the team's uart_trx transmitter, on the same clk_50m domain.
- Frame format: 8N1, LSB first, line idle high.
- Samples the serial line on a 16x-baud enable strobe from the shared baud generator.
- Presents each received byte with a sticky ready flag that the consumer clears.
- Reports framing and overrun errors.

Parameters:
OVERSAMPLE, 16, clken ticks per bit period; power of two, minimum 8.
MID, OVERSAMPLE/2-1 (7), tick index treated as bit centre.

Ports:
clk_50m  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
rx  input  1  serial line, asynchronous to clk_50m, idle high
clken  input  1  single-cycle strobe at 16x baud rate
rdy_clr  input  1  consumer acknowledge; clears rdy, frame_err and overrun
dout  output  8  last good received byte
rdy  output  1  dout holds an unacknowledged byte
frame_err  output  1  last frame had stop bit = 0
overrun  output  1  good byte completed while rdy was still set
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: dout=0x00, rdy=0, frame_err=0, overrun=0, state=IDLE, counters=0, both sync flops=1.
- rx passes through a 2-flop synchronizer; rx_s denotes its output. All sampling uses rx_s, and only on cycles with clken=1.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3. sample is a 4-bit tick counter; bitpos is a 3-bit counter.
- IDLE: on clken with rx_s=0, go to START with sample=0.
- START: on each clken, sample increments.
  - If rx_s=1 at or before sample==MID, the start was a glitch: return to IDLE with no flags changed.
  - At sample==MID with rx_s=0: go to DATA with sample=0, bitpos=0.
- DATA: on each clken, sample increments and wraps at OVERSAMPLE-1.
  - At sample==OVERSAMPLE-1 (bit centre): shreg[bitpos]<=rx_s.
  - If bitpos==7, go to STOP; otherwise bitpos increments.
- STOP: on each clken, sample increments. At sample==OVERSAMPLE-1, go to IDLE and evaluate the stop bit:
  - rx_s=1: dout<=shreg, rdy<=1, frame_err<=0. If rdy was 1 and rdy_clr=0 this cycle, overrun<=1. The new byte always overwrites dout.
  - rx_s=0: frame_err<=1. dout and rdy are unchanged.
- Returning to IDLE at stop-bit centre allows back-to-back frames with no gap.
- rdy_clr=1 clears rdy, frame_err and overrun on the next edge.
  - If rdy_clr coincides with a good-byte completion, the set wins: rdy=1, overrun=0.
  - If rdy_clr coincides with a bad-stop completion, frame_err=1.
- Latency: rdy rises on the clk_50m edge following the clken tick at stop-bit centre. Line-to-sample skew is 2 clk_50m cycles from the synchronizer.
- clken is ignored in all states when 0. Behaviour with clken held high continuously is the same as a 50 MHz baud x16 and is legal.
- rst asserted mid-frame aborts the frame immediately and restores all reset values. No partial byte ever reaches dout.
- rx_busy = (state != IDLE), combinational from state.

Decomposition:
- Shared package uart_pkg: state constants IDLE/START/DATA/STOP and the OVERSAMPLE default. uart_trx and uart_rcv both use it.
- One sub-module, uart_sync2: 2-flop synchronizer with async reset to 1, reusable for other async inputs.
- The FSM, counters and flags stay in uart_rcv.

Test Plan:
1. Drive 0xA5 as 8N1 at 16 clken ticks/bit -> rdy=1 with dout=0xA5, frame_err=0; rdy_clr pulse -> rdy=0 next cycle.
2. rx low for 5 ticks, then high -> rx_busy pulses and returns to IDLE; rdy, frame_err and dout unchanged.
3. Frame 0x3C with stop bit driven 0 -> frame_err=1, rdy=0, dout keeps its previous value; next good frame 0x81 -> frame_err=0, dout=0x81.
4. Back-to-back frames 0x55 then 0xC3, no idle gap, no rdy_clr -> overrun=1, dout=0xC3, rdy=1; rdy_clr -> all three flags clear.
5. rdy_clr asserted exactly on the completion edge of frame 0x7E -> rdy=1, overrun=0, dout=0x7E.
6. rst asserted mid-way through data bits of 0xFF -> all outputs at reset values that cycle; after release, frame 0x12 -> dout=0x12, no error flags.
